// File: rtl/mul_ctrl.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, signed or unsigned
// operands, with a valid/ready handshake on both operand and result sides.
module mul_ctrl #(
  parameter int WIDTH = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               sel,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out,
  output logic               busy,
  output logic [1:0]         dbg_state
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);

  // Handshake: a transfer happens on a rising edge where valid && ready on that side;
  // valid never depends on ready, and out is held stable while out_valid is high.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    mag_a_q, mag_a_d;
  logic [WIDTH-1:0] mag_b_q, mag_b_d;
  logic             sign_q, sign_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]    out_q, out_d;

  logic             neg_a, neg_b;
  logic [PW-1:0]    a_ext;
  logic [PW-1:0]    acc_sum;

  always_comb begin
    state_d = state_q;
    mag_a_d = mag_a_q;
    mag_b_d = mag_b_q;
    sign_d  = sign_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    out_d   = out_q;

    neg_a   = sel & a[WIDTH-1];
    neg_b   = sel & b[WIDTH-1];
    a_ext   = {{WIDTH{neg_a}}, a};
    // mag_a_q is pre-shifted each cycle, so it always holds |a| << i.
    acc_sum = acc_q + (mag_b_q[0] ? mag_a_q : '0);

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          mag_a_d = neg_a ? (~a_ext + PW'(1)) : a_ext;
          mag_b_d = neg_b ? (~b + WIDTH'(1)) : b;
          sign_d  = sel & (a[WIDTH-1] ^ b[WIDTH-1]);
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        acc_d   = acc_sum;
        mag_a_d = mag_a_q << 1;
        mag_b_d = mag_b_q >> 1;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          out_d   = sign_q ? (~acc_sum + PW'(1)) : acc_sum;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      mag_a_q <= '0;
      mag_b_q <= '0;
      sign_q  <= 1'b0;
      acc_q   <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      mag_a_q <= mag_a_d;
      mag_b_q <= mag_b_d;
      sign_q  <= sign_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign out       = out_q;
  assign dbg_state = state_q;

endmodule
